// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t    : fetch sequencer states (3-bit encoding)
//   NOP_INSTR        : word presented by the output register out of reset
//   DEFAULT_RESET_PC : default first fetch address
//   PC_INCR          : sequential PC step
//   is_aligned()     : word-alignment test for fetch addresses
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    FULL  = 3'd3,
    DRAIN = 3'd4,
    FAULT = 3'd5
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req_valid / imem_req_ready : request handshake
//   imem_req_addr                   : word-aligned fetch address
//   imem_rsp_valid                  : response strobe, one per accepted request
//   imem_rsp_data                   : instruction word
//   imem_rsp_err                    : bus error qualifying imem_rsp_valid
// master : fetch stage side, slave : memory side.
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err
  );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage feeding the control decoder. Keeps the PC, issues
// one outstanding request at a time to instruction memory, and hands the
// returned word with its PC to the decoder through a one-entry valid/ready
// register. Redirects from execute override everything; responses belonging
// to requests issued before a redirect are drained and discarded.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem            : instruction-memory bus (master side)
//   redirect_valid  : PC redirect from execute, redirect_pc is the target
//   instr_valid/instr_ready : output register handshake
//   instruction, instr_pc, instr_pc_plus4 : output register contents
//   fetch_fault     : sticky fault (bus error or misaligned target),
//                     cleared by the next aligned redirect
// ---------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_fetch_if.master   imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic            fetch_fault
);

  fetch_state_t    state_reg;
  logic [XLEN-1:0] pc_reg;

  logic req_fire;
  logic rsp_accept;
  logic consume;
  logic redirect_misaligned;
  logic pending_after_redirect;

  // In FULL the request is a pass-through of instr_ready so the next fetch
  // goes out in the same cycle the decoder takes the current entry.
  assign imem.imem_req_valid = (state_reg == FETCH) ||
                               ((state_reg == FULL) && instr_ready);
  assign imem.imem_req_addr  = pc_reg;

  assign req_fire   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_accept = (state_reg == WAIT) && imem.imem_rsp_valid &&
                      !imem.imem_rsp_err && !redirect_valid;
  assign consume    = (state_reg == FULL) && instr_ready;

  assign redirect_misaligned = !is_aligned(redirect_pc);

  // A request is still owed a response after this edge: either one was just
  // accepted, or we were already waiting and nothing arrived this cycle.
  assign pending_after_redirect =
      req_fire ||
      (((state_reg == WAIT) || (state_reg == DRAIN)) && !imem.imem_rsp_valid);

  // Sequencer and fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      fetch_fault <= redirect_misaligned;
      if (pending_after_redirect)
        state_reg <= DRAIN;
      else if (redirect_misaligned)
        state_reg <= FAULT;
      else
        state_reg <= FETCH;
    end else begin
      case (state_reg)
        IDLE:  state_reg <= FETCH;
        FETCH: if (req_fire) state_reg <= WAIT;
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (imem.imem_rsp_err) begin
              fetch_fault <= 1'b1;
              state_reg   <= FAULT;
            end else begin
              state_reg   <= FULL;
            end
          end
        end
        FULL: begin
          if (instr_ready)
            state_reg <= imem.imem_req_ready ? WAIT : FETCH;
        end
        DRAIN: begin
          // pc already holds the redirect target; a misaligned one was
          // flagged at redirect time and must not be fetched.
          if (imem.imem_rsp_valid)
            state_reg <= is_aligned(pc_reg) ? FETCH : FAULT;
        end
        FAULT:   state_reg <= FAULT;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_reg <= RESET_PC;
    else if (redirect_valid)
      pc_reg <= redirect_pc;
    else if (rsp_accept)
      pc_reg <= pc_reg + PC_INCR;
  end

  // Output register towards the decoder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid    <= 1'b0;
      instruction    <= NOP_INSTR;
      instr_pc       <= RESET_PC;
      instr_pc_plus4 <= RESET_PC + PC_INCR;
    end else if (redirect_valid) begin
      instr_valid    <= 1'b0;
    end else if (rsp_accept) begin
      instr_valid    <= 1'b1;
      instruction    <= imem.imem_rsp_data;
      instr_pc       <= pc_reg;
      instr_pc_plus4 <= pc_reg + PC_INCR;
    end else if (consume) begin
      instr_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_if imem ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  bit          mem_out = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          mem_lat_min = 1;
  int          mem_lat_max = 1;
  int          mem_ready_pct = 100;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  bit          rand_err = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0050_0093;
  endfunction

  function automatic bit mem_is_err(input logic [31:0] a);
    return (a == err_addr) || (rand_err && (a[6:2] == 5'd19));
  endfunction

  // ---------------- samples (taken at negedge) ----------------
  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_err, s_redirect;
  logic        s_instr_valid, s_instr_ready, s_fault;
  logic [31:0] s_req_addr, s_redirect_pc, s_instruction, s_instr_pc, s_plus4;

  // ---------------- transaction-level reference ----------------
  bit          model_on = 1'b0;
  logic [31:0] exp_pc = '0;
  bit          m_fault = 1'b0;
  bit          m_live = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  int          n_consumed = 0;

  task automatic model_cycle();
    check32("fault_flag", {31'b0, s_fault}, {31'b0, m_fault});
    if (m_fault) begin
      check32("fault_no_instr", {31'b0, s_instr_valid}, 32'd0);
      check32("fault_no_req", {31'b0, s_req_valid}, 32'd0);
    end
    if (prev_stall) begin
      check32("stall_valid", {31'b0, s_req_valid}, 32'd1);
      check32("stall_addr", s_req_addr, prev_addr);
    end
    prev_stall = s_req_valid && !s_req_ready && !s_instr_valid && !s_redirect;
    prev_addr  = s_req_addr;
    if (s_instr_valid && s_instr_ready && !s_redirect) begin
      check32("rnd_pc", s_instr_pc, exp_pc);
      check32("rnd_word", s_instruction, mem_word(exp_pc));
      check32("rnd_plus4", s_plus4, exp_pc + 32'd4);
      $display("txn consume pc=%h instr=%h", s_instr_pc, s_instruction);
      exp_pc = exp_pc + 32'd4;
      n_consumed++;
    end
    if (s_rsp_valid) begin
      if (m_live && !s_redirect && s_rsp_err) m_fault = 1'b1;
      m_live = 1'b0;
    end
    if (s_req_valid && s_req_ready) begin
      if (!s_redirect) check32("rnd_req_addr", s_req_addr, exp_pc);
      m_live = !s_redirect;
    end
    if (s_redirect) begin
      exp_pc  = s_redirect_pc;
      m_fault = (s_redirect_pc[1:0] != 2'b00);
      m_live  = 1'b0;
    end
  endtask

  // One clock cycle: sample at negedge, then update the memory after the edge.
  task automatic step();
    @(negedge clk);
    s_req_valid   = imem.imem_req_valid;
    s_req_ready   = imem.imem_req_ready;
    s_req_addr    = imem.imem_req_addr;
    s_rsp_valid   = imem.imem_rsp_valid;
    s_rsp_err     = imem.imem_rsp_err;
    s_redirect    = redirect_valid;
    s_redirect_pc = redirect_pc;
    s_instr_valid = instr_valid;
    s_instr_ready = instr_ready;
    s_instruction = instruction;
    s_instr_pc    = instr_pc;
    s_plus4       = instr_pc_plus4;
    s_fault       = fetch_fault;
    if (s_req_valid) begin
      check32("one_outstanding", {31'b0, mem_out}, 32'd0);
      check32("req_aligned", {30'b0, s_req_addr[1:0]}, 32'd0);
    end
    if (model_on) model_cycle();
    @(posedge clk);
    #1;
    if (s_rsp_valid) mem_out = 1'b0;
    else if (mem_out && mem_cnt > 0) mem_cnt--;
    if (s_req_valid && s_req_ready) begin
      mem_out  = 1'b1;
      mem_addr = s_req_addr;
      mem_cnt  = int'($urandom_range(mem_lat_max, mem_lat_min)) - 1;
    end
    imem.imem_rsp_valid = mem_out && (mem_cnt == 0);
    imem.imem_rsp_data  = imem.imem_rsp_valid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    imem.imem_rsp_err   = imem.imem_rsp_valid && mem_is_err(mem_addr);
    imem.imem_req_ready = ($urandom_range(99, 0) < mem_ready_pct);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check32({tag, "_instr"}, instruction, NOP_INSTR);
    check32({tag, "_pc"}, instr_pc, 32'h0);
    check32({tag, "_plus4"}, instr_pc_plus4, 32'h4);
    check32({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
    check32({tag, "_req"}, {31'b0, imem.imem_req_valid}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] target;
    int          lat;
    bit          err;
    bit          exp_fault;
    bit          exp_req;
    logic [31:0] exp_word;
    logic [31:0] exp_plus4;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit          saw_req;
    bit          early_valid;
    logic [31:0] first_addr;

    vecs[0] = '{32'h0000_0100, 1, 1'b0, 1'b0, 1'b1, mem_word(32'h100),  32'h0000_0104, 32'h0000_0104};
    vecs[1] = '{32'h0000_2000, 3, 1'b0, 1'b0, 1'b1, mem_word(32'h2000), 32'h0000_2004, 32'h0000_2004};
    vecs[2] = '{32'hFFFF_FFFC, 2, 1'b0, 1'b0, 1'b1, mem_word(32'hFFFF_FFFC), 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h0000_000C, 1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{32'h0000_0102, 1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{32'h0000_0200, 1, 1'b0, 1'b0, 1'b1, mem_word(32'h200),  32'h0000_0204, 32'h0000_0204};
    vecs[6] = '{32'h0000_0003, 2, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[7] = '{32'h0000_0040, 2, 1'b0, 1'b0, 1'b1, mem_word(32'h40),   32'h0000_0044, 32'h0000_0044};

    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    imem.imem_rsp_err   = 1'b0;

    // ---- A: reset state and first fetch ----
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();
    check32("a_idle_req", {31'b0, s_req_valid}, 32'd0);
    step();
    check32("a_req0_valid", {31'b0, s_req_valid}, 32'd1);
    check32("a_req0_addr", s_req_addr, 32'h0);
    step();
    check32("a_rsp0", {31'b0, s_rsp_valid}, 32'd1);
    step();
    check32("a_valid", {31'b0, s_instr_valid}, 32'd1);
    check32("a_instr", s_instruction, 32'h0050_0093);
    check32("a_pc", s_instr_pc, 32'h0);
    check32("a_plus4", s_plus4, 32'h4);
    check32("a_b2b_req", {31'b0, s_req_valid}, 32'd1);
    check32("a_b2b_addr", s_req_addr, 32'h4);
    $display("txn seqA first fetch done");

    // ---- B: backpressure while FULL ----
    instr_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check32("b_hold_valid", {31'b0, s_instr_valid}, 32'd1);
      check32("b_hold_pc", s_instr_pc, 32'h4);
      check32("b_hold_instr", s_instruction, mem_word(32'h4));
      check32("b_hold_noreq", {31'b0, s_req_valid}, 32'd0);
    end
    mem_lat_min = 3;
    mem_lat_max = 3;
    instr_ready = 1'b1;
    step();
    check32("b_req8_valid", {31'b0, s_req_valid}, 32'd1);
    check32("b_req8_addr", s_req_addr, 32'h8);
    $display("txn seqB backpressure done");

    // ---- C: redirect in WAIT, stale response arrives later ----
    instr_ready = 1'b0;
    pulse_redirect(32'h100);
    mem_lat_min = 1;
    mem_lat_max = 1;
    saw_req = 1'b0;
    early_valid = 1'b0;
    first_addr = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!saw_req && s_instr_valid) early_valid = 1'b1;
      if (!saw_req && s_req_valid) begin
        saw_req = 1'b1;
        first_addr = s_req_addr;
      end
    end
    check32("c_no_stale", {31'b0, early_valid}, 32'd0);
    check32("c_req_addr", first_addr, 32'h100);
    check32("c_valid", {31'b0, s_instr_valid}, 32'd1);
    check32("c_pc", s_instr_pc, 32'h100);
    $display("txn seqC redirect in WAIT done");

    // ---- D: redirect coincident with response ----
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    pulse_redirect(32'h300);
    check32("d_rsp_same_cycle", {31'b0, s_rsp_valid}, 32'd1);
    step();
    check32("d_fetch_valid", {31'b0, s_req_valid}, 32'd1);
    check32("d_fetch_addr", s_req_addr, 32'h300);
    check32("d_not_delivered", {31'b0, s_instr_valid}, 32'd0);
    repeat (4) step();
    check32("d_pc", s_instr_pc, 32'h300);
    $display("txn seqD redirect with response done");

    // ---- table of redirect vectors ----
    foreach (vecs[k]) begin
      mem_lat_min = vecs[k].lat;
      mem_lat_max = vecs[k].lat;
      err_addr    = vecs[k].err ? vecs[k].target : 32'hFFFF_FFFF;
      instr_ready = 1'b0;
      pulse_redirect(vecs[k].target);
      saw_req = 1'b0;
      first_addr = '0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (!saw_req && s_req_valid) begin
          saw_req = 1'b1;
          first_addr = s_req_addr;
        end
      end
      check32("v_fault", {31'b0, s_fault}, {31'b0, vecs[k].exp_fault});
      check32("v_valid", {31'b0, s_instr_valid}, {31'b0, !vecs[k].exp_fault});
      check32("v_saw_req", {31'b0, saw_req}, {31'b0, vecs[k].exp_req});
      if (vecs[k].exp_req) check32("v_req_addr", first_addr, vecs[k].target);
      if (!vecs[k].exp_fault) begin
        check32("v_pc", s_instr_pc, vecs[k].target);
        check32("v_word", s_instruction, vecs[k].exp_word);
        check32("v_plus4", s_plus4, vecs[k].exp_plus4);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check32("v_next_valid", {31'b0, s_req_valid}, 32'd1);
        check32("v_next_addr", s_req_addr, vecs[k].exp_next);
      end
      $display("txn vector %0d target=%h fault=%0d pc=%h", k, vecs[k].target, s_fault, s_instr_pc);
    end
    err_addr = 32'hFFFF_FFFF;

    // ---- E: reset asserted mid-transaction ----
    mem_lat_min = 3;
    mem_lat_max = 3;
    pulse_redirect(32'h500);
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    mem_out = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_err   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_lat_min = 1;
    model_on = 1'b1;
    exp_pc = 32'h0;
    m_fault = 1'b0;
    m_live = 1'b0;
    prev_stall = 1'b0;
    step();
    step();
    check32("e_req0_addr", s_req_addr, 32'h0);
    check32("e_req0_valid", {31'b0, s_req_valid}, 32'd1);
    $display("txn seqE mid-transaction reset done");

    // ---- randomized run against the transaction-level reference ----
    mem_ready_pct = 70;
    rand_err = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      redirect_valid = ($urandom_range(99, 0) < 4);
      if (redirect_valid) begin
        case ($urandom_range(9, 0))
          0:       redirect_pc = {$urandom_range(255, 0), 2'b00} | {30'b0, 2'($urandom_range(3, 1))};
          1:       redirect_pc = 32'hFFFF_FFF8;
          default: redirect_pc = {22'b0, 8'($urandom_range(255, 0)), 2'b00};
        endcase
      end
      instr_ready = ($urandom_range(99, 0) < 60);
      step();
    end
    redirect_valid = 1'b0;
    model_on = 1'b0;
    n_cmp++;
    if (n_consumed < 100) begin
      n_bad++;
      $display("FAIL progress: actual %0d consumed required at least 100", n_consumed);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and issues one outstanding request at a time to instruction memory over a valid/ready request port plus a response-valid port.
- Presents the returned word with its PC to the decoder through a one-entry valid/ready output register.
- Accepts redirects (taken branch, jal, jalr) from execute and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
- XLEN, 32, address and instruction width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address; always equals pc.
- imem_rsp_valid  in  1  response word valid; at most one per accepted request, any latency of 1 cycle or more.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  bus error qualifying imem_rsp_valid.
- redirect_valid  in  1  PC redirect from execute.
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  instruction register holds a valid entry.
- instr_ready  in  1  decoder consumes the entry.
- instruction  out  32  registered instruction word, feeds the decoder input.
- instr_pc  out  32  PC of instruction.
- instr_pc_plus4  out  32  instr_pc + 4; feeds the link value for jal/jalr.
- fetch_fault  out  1  sticky fault flag, cleared by redirect.

Behaviour:
- Reset, asynchronous:
  - state=IDLE, pc=RESET_PC.
  - instr_valid=0, instruction=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_pc_plus4=RESET_PC+4.
  - fetch_fault=0, imem_req_valid=0.
  - Asserting reset mid-transaction abandons any outstanding response; the memory side must be reset together with this block.
- States: IDLE, FETCH, WAIT, FULL, DRAIN, FAULT.
- IDLE -> FETCH on the first clock after reset release.
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_valid && imem_req_ready -> WAIT.
  - Request valid and address stay stable until accepted.
- WAIT:
  - On imem_rsp_valid && !imem_rsp_err: instruction<=data, instr_pc<=pc, instr_pc_plus4<=pc+4, pc<=pc+4, instr_valid<=1 -> FULL.
  - On imem_rsp_valid && imem_rsp_err: fetch_fault<=1 -> FAULT, with instr_valid remaining 0.
- FULL:
  - instr_valid=1; contents are held while instr_ready=0.
  - imem_req_valid = instr_ready, a combinational pass-through that allows back-to-back issue.
  - instr_ready && imem_req_ready: instr_valid<=0 -> WAIT.
  - instr_ready && !imem_req_ready: instr_valid<=0 -> FETCH.
  - Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- DRAIN:
  - No request is issued.
  - On imem_rsp_valid the response (data or error) is discarded -> FETCH.
- FAULT:
  - No requests issued; instr_valid=0; fetch_fault=1.
  - Leaves only on redirect.
- Redirect has highest priority in every state:
  - pc<=redirect_pc and instr_valid<=0, discarding any held entry even if instr_ready=1 in the same cycle.
  - fetch_fault<=0.
  - Next state:
    - A request is outstanding and not answered this cycle (WAIT without rsp, FETCH with handshake this cycle, FULL with handshake this cycle): -> DRAIN.
    - Already in DRAIN with no response this cycle: stay in DRAIN; only pc updates.
    - Otherwise, including WAIT/DRAIN with rsp_valid in the same cycle (the response is discarded): -> FETCH.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - pc is still updated and fetch_fault<=1.
  - Target state is FAULT instead of FETCH, or DRAIN-then-FAULT if a request is outstanding.
  - No request is ever issued to a misaligned address.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no flag.
- imem_rsp_valid outside WAIT/DRAIN is a protocol violation and is ignored.

Decomposition:
- Shared package (fetch_pkg):
  - state enumeration localparams, 3 bits.
  - NOP_INSTR = 32'h0000_0013.
  - default RESET_PC.
  - PC_INCR = 4.
- Single module; no sub-module is needed. The PC register and the output register are kept in separate always blocks.

Test Plan:
- Reset release, RESET_PC=0, memory ready=1 with 1-cycle latency returning 32'h00500093, instr_ready=1 -> first req addr 0 at cycle 1; instr_valid with instr_pc=0 and instr_pc_plus4=4; next req addr 4 issued in the same cycle the entry is consumed.
- Hold instr_ready=0 for 5 cycles while FULL -> instruction/instr_pc stable; imem_req_valid=0; release -> req addr 8 issued.
- redirect_pc=32'h100 while in WAIT, response arrives 2 cycles later -> response dropped, instr_valid never asserted for it; next req addr 32'h100; instr_pc=32'h100 on delivery.
- redirect in the same cycle as imem_rsp_valid in WAIT -> the word is not delivered; FETCH at the target the next cycle.
- imem_rsp_err=1 on addr 32'h0C -> fetch_fault=1, instr_valid=0, no further requests; redirect to 32'h200 -> fault clears, req addr 32'h200.
- redirect_pc=32'h102 -> fetch_fault=1, no request issued; pc=32'hFFFF_FFFC fetch -> next addr 32'h0.
